// File: rtl/retire_stage.sv
// retire_stage: 3-wide in-order commit stage sitting behind the ROB.
// Qualifies the retire lanes, cuts at the oldest taken branch, removes
// duplicate register writes within a group, and registers the RF write
// ports. A taken branch raises a one-cycle squash/redirect pulse, after
// which the stage ignores its inputs for a fixed recovery window.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_RUN     | normal retirement; lanes are qualified and committed
// ST_SQUASH  | first cycle after the squash pulse; inputs ignored
// ST_RECOVER | recovery window; inputs ignored until recover_cnt hits 0

module retire_stage #(
  parameter int XLEN           = 32,
  parameter int NUM_LANES      = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_LANES-1:0]      rt_valid,
  input  logic [5*NUM_LANES-1:0]    rt_dest_idx,
  input  logic [XLEN*NUM_LANES-1:0] rt_value,
  input  logic [NUM_LANES-1:0]      rt_take_branch,
  input  logic [XLEN*NUM_LANES-1:0] rt_npc,
  output logic [NUM_LANES-1:0]      rf_wr_en,
  output logic [5*NUM_LANES-1:0]    rf_wr_idx,
  output logic [XLEN*NUM_LANES-1:0] rf_wr_data,
  output logic                      squash_flag,
  output logic [XLEN-1:0]           redirect_pc,
  output logic [1:0]                retire_num,
  output logic [63:0]               instret,
  output logic                      busy_recover
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SQUASH  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Counter reload for the recovery window; the SQUASH cycle itself
  // accounts for one ignored cycle beyond the RECOVER cycles.
  localparam logic [3:0] RC_LOAD = (RECOVER_CYCLES == 0) ? 4'd0 : 4'(RECOVER_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [3:0]                recover_cnt_q, recover_cnt_d;

  logic [NUM_LANES-1:0]      rf_wr_en_q, rf_wr_en_d;
  logic [5*NUM_LANES-1:0]    rf_wr_idx_q, rf_wr_idx_d;
  logic [XLEN*NUM_LANES-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                      squash_q, squash_d;
  logic [XLEN-1:0]           redirect_pc_q, redirect_pc_d;
  logic [1:0]                retire_num_q, retire_num_d;
  logic [63:0]               instret_q, instret_d;
  logic                      busy_q, busy_d;

  logic [4:0]                dest [NUM_LANES];
  logic [NUM_LANES-1:0]      eff;
  logic [NUM_LANES-1:0]      hit;
  logic [NUM_LANES-1:0]      commit;
  logic [NUM_LANES-1:0]      wen;
  logic                      cut;

  // Lane qualification, oldest-branch cut and youngest-writer dedup.
  always_comb begin
    eff    = '0;
    hit    = '0;
    commit = '0;
    wen    = '0;
    cut    = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      dest[i] = rt_dest_idx[5*i +: 5];
    end
    if (state_q == ST_RUN) begin
      eff[0] = rt_valid[0];
      for (int i = 1; i < NUM_LANES; i++) begin
        eff[i] = rt_valid[i] & eff[i-1];
      end
      hit = eff & rt_take_branch;
      cut = |hit;
      // Lanes younger than the first hit are dropped.
      commit = eff;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (hit[i]) begin
          for (int j = 0; j < NUM_LANES; j++) begin
            if (j > i) commit[j] = 1'b0;
          end
        end
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      wen[i] = commit[i] & (dest[i] != 5'd0);
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (commit[j] && (dest[j] == dest[i])) wen[i] = 1'b0;
      end
    end
  end

  // Next values for the registered RF port, counters and redirect.
  always_comb begin
    rf_wr_en_d    = wen;
    rf_wr_idx_d   = '0;
    rf_wr_data_d  = '0;
    retire_num_d  = 2'd0;
    redirect_pc_d = redirect_pc_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wen[i]) begin
        rf_wr_idx_d[5*i +: 5]     = dest[i];
        rf_wr_data_d[XLEN*i +: XLEN] = rt_value[XLEN*i +: XLEN];
      end
      retire_num_d = retire_num_d + 2'(commit[i]);
    end
    // Scan youngest to oldest so the oldest flagged lane wins.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (hit[i]) redirect_pc_d = rt_npc[XLEN*i +: XLEN];
    end
    instret_d = instret_q + 64'(retire_num_d);
    squash_d  = cut;
    busy_d    = cut | (state_q != ST_RUN);
  end

  // FSM next-state logic and recovery counter.
  always_comb begin
    state_d       = state_q;
    recover_cnt_d = recover_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (cut) state_d = ST_SQUASH;
      end
      ST_SQUASH: begin
        if (RECOVER_CYCLES == 0) begin
          state_d = ST_RUN;
        end else begin
          recover_cnt_d = RC_LOAD;
          state_d       = ST_RECOVER;
        end
      end
      ST_RECOVER: begin
        if (recover_cnt_q == 4'd0) state_d = ST_RUN;
        else recover_cnt_d = recover_cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      recover_cnt_q <= 4'd0;
      rf_wr_en_q    <= '0;
      rf_wr_idx_q   <= '0;
      rf_wr_data_q  <= '0;
      squash_q      <= 1'b0;
      redirect_pc_q <= '0;
      retire_num_q  <= 2'd0;
      instret_q     <= 64'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      recover_cnt_q <= recover_cnt_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_idx_q   <= rf_wr_idx_d;
      rf_wr_data_q  <= rf_wr_data_d;
      squash_q      <= squash_d;
      redirect_pc_q <= redirect_pc_d;
      retire_num_q  <= retire_num_d;
      instret_q     <= instret_d;
      busy_q        <= busy_d;
    end
  end

  assign rf_wr_en     = rf_wr_en_q;
  assign rf_wr_idx    = rf_wr_idx_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign squash_flag  = squash_q;
  assign redirect_pc  = redirect_pc_q;
  assign retire_num   = retire_num_q;
  assign instret      = instret_q;
  assign busy_recover = busy_q;

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed vector table, randomized run against a
// lane-counting reference model, and an asynchronous reset mid-recovery.

module tb_retire_stage;

  localparam int XLEN = 32;
  localparam int RC   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  rt_valid;
  logic [14:0] rt_dest_idx;
  logic [95:0] rt_value;
  logic [2:0]  rt_take_branch;
  logic [95:0] rt_npc;
  logic [2:0]  rf_wr_en;
  logic [14:0] rf_wr_idx;
  logic [95:0] rf_wr_data;
  logic        squash_flag;
  logic [31:0] redirect_pc;
  logic [1:0]  retire_num;
  logic [63:0] instret;
  logic        busy_recover;

  retire_stage #(.XLEN(XLEN), .NUM_LANES(3), .RECOVER_CYCLES(RC)) dut (
    .clock(clock), .reset(reset),
    .rt_valid(rt_valid), .rt_dest_idx(rt_dest_idx), .rt_value(rt_value),
    .rt_take_branch(rt_take_branch), .rt_npc(rt_npc),
    .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
    .squash_flag(squash_flag), .redirect_pc(redirect_pc),
    .retire_num(retire_num), .instret(instret), .busy_recover(busy_recover)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state and expectations for the current cycle.
  int          m_ignore;
  logic [63:0] m_instret;
  logic [31:0] m_pc;
  logic [2:0]  e_en;
  logic [1:0]  e_num;
  logic        e_sq;
  logic        e_busy;
  logic [14:0] e_idx;
  logic [95:0] e_data;

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] dest;
    logic [95:0] value;
    logic [2:0]  tb;
    logic [95:0] npc;
    logic [2:0]  exp_en;
    logic [1:0]  exp_num;
    logic        exp_sq;
    logic        exp_busy;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] v, input logic [4:0] d0, input logic [4:0] d1,
                         input logic [4:0] d2, input logic [2:0] tb, input logic [95:0] npc,
                         input logic [2:0] en, input logic [1:0] num, input logic sq,
                         input logic busy, input logic [31:0] pc);
    vec_t t;
    t.valid = v;  t.dest = {d2, d1, d0};
    t.value = {32'h33, 32'h22, 32'h11};
    t.tb = tb;  t.npc = npc;
    t.exp_en = en;  t.exp_num = num;  t.exp_sq = sq;  t.exp_busy = busy;  t.exp_pc = pc;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic [2:0] v, input logic [14:0] d, input logic [95:0] val,
                       input logic [2:0] tb, input logic [95:0] npc);
    rt_valid = v;  rt_dest_idx = d;  rt_value = val;  rt_take_branch = tb;  rt_npc = npc;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Lane rules from first principles: count the valid prefix, find the
  // oldest flagged lane in it, and let a lane write only if no younger
  // committed lane targets the same register.
  task automatic model_step();
    int n;
    int cut;
    int nc;
    e_en = 3'b000;  e_idx = '0;  e_data = '0;
    if (m_ignore > 0) begin
      e_num = 2'd0;  e_sq = 1'b0;  e_busy = 1'b1;
      m_ignore--;
    end else begin
      n = 0;
      while (n < 3 && rt_valid[n]) n++;
      cut = -1;
      for (int i = 0; i < n; i++) if (cut < 0 && rt_take_branch[i]) cut = i;
      nc = (cut >= 0) ? cut + 1 : n;
      for (int i = 0; i < nc; i++) begin
        logic ok;
        ok = (rt_dest_idx[5*i +: 5] != 5'd0);
        for (int j = i + 1; j < nc; j++)
          if (rt_dest_idx[5*j +: 5] == rt_dest_idx[5*i +: 5]) ok = 1'b0;
        if (ok) begin
          e_en[i] = 1'b1;
          e_idx[5*i +: 5] = rt_dest_idx[5*i +: 5];
          e_data[32*i +: 32] = rt_value[32*i +: 32];
        end
      end
      e_num = 2'(nc);
      e_sq = (cut >= 0);
      e_busy = e_sq;
      if (cut >= 0) begin
        m_pc = rt_npc[32*cut +: 32];
        m_ignore = 1 + RC;
      end
    end
    m_instret = m_instret + 64'(e_num);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wr_en"}, 64'(rf_wr_en), 64'(e_en));
    check({tag, ".retire_num"}, 64'(retire_num), 64'(e_num));
    check({tag, ".squash"}, 64'(squash_flag), 64'(e_sq));
    check({tag, ".busy"}, 64'(busy_recover), 64'(e_busy));
    check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(m_pc));
    check({tag, ".instret"}, instret, m_instret);
    for (int i = 0; i < 3; i++) begin
      if (e_en[i]) begin
        check({tag, ".wr_idx"}, 64'(rf_wr_idx[5*i +: 5]), 64'(e_idx[5*i +: 5]));
        check({tag, ".wr_data"}, 64'(rf_wr_data[32*i +: 32]), 64'(e_data[32*i +: 32]));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wr_en"}, 64'(rf_wr_en), 64'd0);
    check({tag, ".wr_idx"}, 64'(rf_wr_idx), 64'd0);
    check({tag, ".wr_data"}, 64'(rf_wr_data), 64'd0);
    check({tag, ".squash"}, 64'(squash_flag), 64'd0);
    check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'd0);
    check({tag, ".retire_num"}, 64'(retire_num), 64'd0);
    check({tag, ".instret"}, instret, 64'd0);
    check({tag, ".busy"}, 64'(busy_recover), 64'd0);
  endtask

  initial begin
    logic [14:0] rd;
    logic [95:0] rv;
    logic [95:0] rn;
    logic [2:0]  rtb;
    int          waited;

    // valid  d0 d1 d2 tb     npc                           en     num sq busy pc
    add_vec(3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 0, 32'h0);
    add_vec(3'b111, 5'd5, 5'd6, 5'd7, 3'b000, 96'h0,                             3'b111, 2'd3, 0, 0, 32'h0);
    add_vec(3'b101, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b001, 2'd1, 0, 0, 32'h0);
    add_vec(3'b111, 5'd0, 5'd4, 5'd4, 3'b000, 96'h0,                             3'b100, 2'd3, 0, 0, 32'h0);
    add_vec(3'b111, 5'd9, 5'd9, 5'd0, 3'b000, 96'h0,                             3'b010, 2'd3, 0, 0, 32'h0);
    add_vec(3'b011, 5'd1, 5'd2, 5'd3, 3'b100, {32'hDEAD, 32'h0, 32'h0},          3'b011, 2'd2, 0, 0, 32'h0);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b010, {32'h0, 32'h400, 32'h0},           3'b011, 2'd2, 1, 1, 32'h400);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'h400);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b001, {32'h0, 32'h0, 32'h900},           3'b000, 2'd0, 0, 1, 32'h400);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'h400);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b001, {32'h0, 32'h0, 32'h800},           3'b001, 2'd1, 1, 1, 32'h800);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'h800);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'h800);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'h800);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b110, {32'hB00, 32'hA00, 32'h0},         3'b011, 2'd2, 1, 1, 32'hA00);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'hA00);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'hA00);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b000, 2'd0, 0, 1, 32'hA00);
    add_vec(3'b111, 5'd1, 5'd2, 5'd3, 3'b000, 96'h0,                             3'b111, 2'd3, 0, 0, 32'hA00);

    // Reset held for three cycles with idle inputs.
    drive(3'b000, '0, '0, 3'b000, '0);
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("in_reset");
    reset = 1'b1;
    cycle();
    check_all_zero("after_release");

    // Directed vector table.
    m_ignore = 0;  m_instret = 64'd0;  m_pc = 32'd0;
    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].dest, vecs[k].value, vecs[k].tb, vecs[k].npc);
      cycle();
      e_en = vecs[k].exp_en;  e_num = vecs[k].exp_num;
      e_sq = vecs[k].exp_sq;  e_busy = vecs[k].exp_busy;
      e_idx = '0;  e_data = '0;
      for (int i = 0; i < 3; i++) begin
        e_idx[5*i +: 5]    = vecs[k].dest[5*i +: 5];
        e_data[32*i +: 32] = vecs[k].value[32*i +: 32];
      end
      m_pc = vecs[k].exp_pc;
      m_instret = m_instret + 64'(vecs[k].exp_num);
      check_outputs($sformatf("vec%0d", k));
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        rd[5*i +: 5]  = 5'($urandom_range(0, 7));
        rv[32*i +: 32] = $urandom;
        rn[32*i +: 32] = $urandom;
        rtb[i] = ($urandom_range(0, 7) == 0);
      end
      drive(3'($urandom_range(0, 7)), rd, rv, rtb, rn);
      model_step();
      cycle();
      check_outputs("rand");
    end

    // Drain any recovery window still open.
    waited = 0;
    while (m_ignore > 0 && waited < 10) begin
      drive(3'b000, '0, '0, 3'b000, '0);
      model_step();
      cycle();
      check_outputs("drain");
      waited++;
    end

    // Asynchronous reset in the middle of recovery.
    drive(3'b111, {5'd7, 5'd6, 5'd5}, {32'h3, 32'h2, 32'h1}, 3'b001, {32'h0, 32'h0, 32'h1234});
    model_step();
    cycle();
    check_outputs("ar_cut");
    drive(3'b111, {5'd7, 5'd6, 5'd5}, {32'h3, 32'h2, 32'h1}, 3'b000, '0);
    model_step();
    cycle();
    check_outputs("ar_squash");
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("ar_async");
    m_ignore = 0;  m_instret = 64'd0;  m_pc = 32'd0;
    drive(3'b000, '0, '0, 3'b000, '0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_step();
    cycle();
    check_outputs("ar_idle");
    drive(3'b111, {5'd7, 5'd6, 5'd5}, {32'h33, 32'h22, 32'h11}, 3'b000, '0);
    model_step();
    cycle();
    check_outputs("ar_resume");
    check("ar_resume.instret3", instret, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- 3-wide in-order commit stage directly downstream of the ROB.
- Consumes the ROB's three retire lanes each cycle and writes committed values into the architectural register file, one registered cycle later.
- When a retiring instruction is flagged take_branch, it commits that instruction and all older lanes, drops the younger lanes, and issues a registered squash plus PC redirect.
- It then runs a fixed recovery window, ignoring inputs, before resuming.

Parameters:
- XLEN, 32, data and PC width.
- NUM_LANES, 3, retire width; fixed, other values unsupported.
- RECOVER_CYCLES, 2, cycles inputs are ignored after the squash pulse (0..15).

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- rt_valid  in  3  per-lane retire valid from the ROB; bit 0 is the oldest lane.
- rt_dest_idx  in  15  per-lane 5-bit destination register; 0 = no write.
- rt_value  in  96  per-lane XLEN result.
- rt_take_branch  in  3  per-lane redirect-required flag.
- rt_npc  in  96  per-lane XLEN redirect target.
- rf_wr_en  out  3  architectural RF write enables.
- rf_wr_idx  out  15  RF write indices.
- rf_wr_data  out  96  RF write data.
- squash_flag  out  1  one-cycle squash pulse to ROB, RS and map table.
- redirect_pc  out  32  fetch target; meaningful only while squash_flag=1.
- retire_num  out  2  count of instructions committed this cycle (0..3).
- instret  out  64  running count of committed instructions.
- busy_recover  out  1  high while in SQUASH or RECOVER; dispatch must stall.

Behaviour:
- Reset (reset=0, asynchronous): state=RUN; every output is 0, including instret and recover_cnt.
- Lane qualification (combinational, in RUN):
  - eff[0]=rt_valid[0].
  - eff[i]=rt_valid[i] & eff[i-1]; this is prefix-only, so a valid lane behind an invalid lane is dropped.
- Branch cut:
  - b = lowest i with eff[i] & rt_take_branch[i].
  - commit[i] = eff[i] & (i <= b); if there is no such b, commit = eff.
- Write-port dedup:
  - Lane i write enable = commit[i] & (dest!=0) & no younger committed lane j>i with the same nonzero dest.
  - The youngest writer wins.
- Outputs are registered; the RF write occurs the cycle after the lanes are presented.
  - rf_wr_* <= the per-lane qualified values.
  - retire_num <= popcount(commit).
  - instret <= instret + popcount(commit), 64-bit wrapping.
- FSM states: RUN, SQUASH, RECOVER.
  - RUN, branch cut found: next=SQUASH; register squash_flag<=1 and redirect_pc<=rt_npc[b]. Commits for lanes <= b occur in the same registered cycle as the pulse.
  - RUN, no cut: stay in RUN; squash_flag<=0.
  - SQUASH (one cycle): all inputs ignored and commit=0. squash_flag<=0. If RECOVER_CYCLES=0, next=RUN; otherwise recover_cnt<=RECOVER_CYCLES-1 and next=RECOVER.
  - RECOVER: inputs ignored. If recover_cnt=0, next=RUN; else decrement recover_cnt.
- busy_recover <= 1 in the cycle that squash_flag is 1, and in every cycle spent in SQUASH or RECOVER.
- redirect_pc holds its last value when squash_flag=0; consumers gate it with squash_flag.
- Boundary cases:
  - take_branch on an invalid lane: ignored.
  - take_branch on lane 0 with lanes 1 and 2 valid: only lane 0 commits; retire_num=1.
  - Multiple flagged lanes: the oldest wins.
  - Reset mid-RECOVER returns to RUN immediately, with squash_flag=0.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs 0, state RUN; with no valid lanes presented, instret stays 0.
- Full retire: valid=3'b111, dest=(5,6,7), values (0x11,0x22,0x33), no branch → next cycle rf_wr_en=3'b111 with matching idx/data, retire_num=3, instret=3.
- Prefix and x0 handling: valid=3'b101 → only lane 0 commits, retire_num=1. Separately, dest=(0,4,4) with all lanes valid → rf_wr_en=3'b100, writing r4=lane2 value, retire_num=3.
- Branch cut: all lanes valid, take_branch=3'b010, npc[1]=0x0000_0400 → next cycle rf_wr_en covers lanes 0 and 1 only, retire_num=2, squash_flag=1, redirect_pc=0x400, busy_recover=1.
- Recovery window with RECOVER_CYCLES=2: present full-valid lanes every cycle after the squash → SQUASH plus 2 RECOVER cycles show rf_wr_en=0, retire_num=0, busy_recover=1, squash_flag=0; commits resume on the 4th cycle after the pulse.
- Async reset during RECOVER: drop reset mid-window → outputs clear without waiting for a clock edge; after release the block is in RUN with instret=0.
